// File: rtl/uart_rx_mid.sv
// uart_rx_mid: 8N1-style UART receiver that feeds an AXI-Stream byte sink.
// Each bit is sampled at its centre. The bit time is prescale*8 clocks, and
// prescale is captured at start detect. Framing errors and overruns are
// reported as single-cycle pulses. DATA_WIDTH must be at least 2.
module uart_rx_mid #(
   parameter int DATA_WIDTH = 8,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   input  logic [15:0]           prescale,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  frame_error,
   output logic                  overrun_error
);

   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                  state_q;
   logic                    sync1_q;
   logic                    rxd_s_q;
   logic [18:0]             cnt_q;
   logic [18:0]             bt_q;
   logic [IW-1:0]           bit_idx_q;
   logic [DATA_WIDTH-1:0]   shift_q;
   logic [DATA_WIDTH-1:0]   shift_d;
   logic [DATA_WIDTH-1:0]   tdata_q;
   logic                    tvalid_q;
   logic                    busy_q;
   logic                    ferr_q;
   logic                    ovr_q;

   // A prescale of zero is treated as one, so the bit time is never zero.
   logic [15:0] ps_eff;
   logic [18:0] bt_now;
   logic [18:0] half_now;
   assign ps_eff   = (prescale == 16'd0) ? 16'd1 : prescale;
   assign bt_now   = {ps_eff, 3'b000};
   assign half_now = {1'b0, ps_eff, 2'b00};

   // The BIG_ENDIAN setting decides which end of the word the first received bit ends up at.
   generate
      if (BIG_ENDIAN) begin : g_msb_first
         assign shift_d = {shift_q[DATA_WIDTH-2:0], rxd_s_q};
      end else begin : g_lsb_first
         assign shift_d = {rxd_s_q, shift_q[DATA_WIDTH-1:1]};
      end
   endgenerate

   // Two-flop synchronizer for the asynchronous line. It resets to idle-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rxd_s_q <= 1'b1;
      end else begin
         sync1_q <= rxd;
         rxd_s_q <= sync1_q;
      end
   end

   // Receive FSM, together with the output word register and the error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bt_q      <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
         // A handshake clears tvalid. A word delivered in the same cycle overrides this below.
         if (tvalid_q && m_axis_tready) begin
            tvalid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (!rxd_s_q) begin
                  state_q <= S_START;
                  cnt_q   <= half_now - 19'd1;
                  bt_q    <= bt_now;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (cnt_q == 19'd0) begin
                  if (!rxd_s_q) begin
                     state_q   <= S_DATA;
                     cnt_q     <= bt_q - 19'd1;
                     bit_idx_q <= '0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q - 19'd1;
               end
            end
            S_DATA: begin
               if (cnt_q == 19'd0) begin
                  shift_q <= shift_d;
                  cnt_q   <= bt_q - 19'd1;
                  if (bit_idx_q == LAST_IDX) begin
                     state_q <= S_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 19'd1;
               end
            end
            S_STOP: begin
               if (cnt_q == 19'd0) begin
                  if (rxd_s_q) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     if (!tvalid_q || m_axis_tready) begin
                        tdata_q  <= shift_q;
                        tvalid_q <= 1'b1;
                     end else begin
                        ovr_q <= 1'b1;
                     end
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= S_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q - 19'd1;
               end
            end
            S_BREAK: begin
               if (rxd_s_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign busy          = busy_q;
   assign frame_error   = ferr_q;
   assign overrun_error = ovr_q;

endmodule

// File: tb/tb_uart_rx_mid.sv
// Testbench for uart_rx_mid. Two receivers, one LSB-first and one MSB-first,
// listen to the same line. A table of clean frames runs first, then
// hand-written sequences exercise the error and reset cases.
module tb_uart_rx_mid;

   logic        clk = 1'b0;
   logic        rst;
   logic        rxd;
   logic [15:0] prescale;
   logic        tready;
   logic [7:0]  tdata, be_tdata;
   logic        tvalid, be_tvalid;
   logic        busy, be_busy;
   logic        ferr, be_ferr;
   logic        ovr, be_ovr;

   always #5 clk = ~clk;

   uart_rx_mid #(.DATA_WIDTH(8), .BIG_ENDIAN(1'b0)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .prescale(prescale),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .busy(busy), .frame_error(ferr), .overrun_error(ovr)
   );

   uart_rx_mid #(.DATA_WIDTH(8), .BIG_ENDIAN(1'b1)) dut_be (
      .clk(clk), .rst(rst), .rxd(rxd), .prescale(prescale),
      .m_axis_tdata(be_tdata), .m_axis_tvalid(be_tvalid), .m_axis_tready(tready),
      .busy(be_busy), .frame_error(be_ferr), .overrun_error(be_ovr)
   );

   int errors = 0;
   int checks = 0;
   int bt = 48;

   // Output monitor. It samples just after the falling edge, once all inputs have settled.
   int beats = 0, be_beats = 0, ferr_n = 0, ovr_n = 0;
   logic [7:0] last_le = 8'h00, last_be = 8'h00;
   always @(negedge clk) begin
      #1;
      if (!rst) begin
         if (tvalid && tready) begin beats++; last_le = tdata; end
         if (be_tvalid && tready) begin be_beats++; last_be = be_tdata; end
         if (ferr) ferr_n++;
         if (ovr) ovr_n++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Holds the line at v for n clocks. It is always called at a falling edge.
   task automatic hold(input logic v, input int n);
      rxd = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_data(input logic [7:0] d);
      hold(1'b0, bt);
      for (int i = 0; i < 8; i++) hold(d[i], bt);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_bits);
      send_data(d);
      hold(stop_v, bt * stop_bits);
   endtask

   typedef struct {
      logic [15:0] ps;
      logic [7:0]  data;
      logic [7:0]  exp_le;
      logic [7:0]  exp_be;
   } vec_t;
   vec_t vecs[7];

   int b0, bb0, f0, o0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{16'd6, 8'h2D, 8'h2D, 8'hB4};
      vecs[1] = '{16'd6, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{16'd6, 8'hFF, 8'hFF, 8'hFF};
      vecs[3] = '{16'd6, 8'h80, 8'h80, 8'h01};
      vecs[4] = '{16'd1, 8'h01, 8'h01, 8'h80};
      vecs[5] = '{16'd0, 8'hC8, 8'hC8, 8'h13};
      vecs[6] = '{16'd2, 8'hA5, 8'hA5, 8'hA5};

      rst = 1'b1; rxd = 1'b1; prescale = 16'd6; tready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tvalid", {31'd0, tvalid}, 32'd0);
      check("reset_tdata", {24'd0, tdata}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_ferr", {31'd0, ferr}, 32'd0);
      check("reset_ovr", {31'd0, ovr}, 32'd0);
      rst = 1'b0;
      hold(1'b1, 4);

      // Clean frames from the table, with tready held high.
      for (int i = 0; i < 7; i++) begin
         prescale = vecs[i].ps;
         bt = ((vecs[i].ps == 16'd0) ? 1 : int'(vecs[i].ps)) * 8;
         b0 = beats; bb0 = be_beats; f0 = ferr_n; o0 = ovr_n;
         send_frame(vecs[i].data, 1'b1, 1);
         hold(1'b1, bt);
         $display("frame %0d ps=%0d data=%h -> le=%h be=%h beats=%0d", i, vecs[i].ps,
                  vecs[i].data, last_le, last_be, beats - b0);
         check("vec_beats", beats - b0, 32'd1);
         check("vec_be_beats", be_beats - bb0, 32'd1);
         check("vec_tdata_le", {24'd0, last_le}, {24'd0, vecs[i].exp_le});
         check("vec_tdata_be", {24'd0, last_be}, {24'd0, vecs[i].exp_be});
         check("vec_ferr", ferr_n - f0, 32'd0);
         check("vec_ovr", ovr_n - o0, 32'd0);
         check("vec_busy_idle", {31'd0, busy}, 32'd0);
      end

      // False start: the line goes low for only 10 clocks.
      prescale = 16'd6; bt = 48;
      b0 = beats; f0 = ferr_n; o0 = ovr_n;
      hold(1'b0, 5);
      check("false_busy_set", {31'd0, busy}, 32'd1);
      hold(1'b0, 5);
      hold(1'b1, 2 * bt);
      $display("false start: beats=%0d busy=%b", beats - b0, busy);
      check("false_beats", beats - b0, 32'd0);
      check("false_busy", {31'd0, busy}, 32'd0);
      check("false_ferr", ferr_n - f0, 32'd0);
      check("false_ovr", ovr_n - o0, 32'd0);

      // Framing error: the stop bit is held low for two bit times.
      b0 = beats; f0 = ferr_n;
      send_data(8'h55);
      hold(1'b0, bt);
      check("brk_ferr_pulse", ferr_n - f0, 32'd1);
      check("brk_busy_mid", {31'd0, busy}, 32'd1);
      check("brk_tvalid", {31'd0, tvalid}, 32'd0);
      hold(1'b0, bt);
      check("brk_busy_held", {31'd0, busy}, 32'd1);
      hold(1'b1, 10);
      $display("break frame: ferr pulses=%0d beats=%0d busy=%b", ferr_n - f0, beats - b0, busy);
      check("brk_busy_released", {31'd0, busy}, 32'd0);
      check("brk_ferr_single", ferr_n - f0, 32'd1);
      check("brk_beats", beats - b0, 32'd0);
      hold(1'b1, bt);

      // Overrun: two back-to-back frames are sent while the sink stalls.
      tready = 1'b0;
      b0 = beats; o0 = ovr_n;
      send_frame(8'h11, 1'b1, 1);
      send_frame(8'h22, 1'b1, 1);
      hold(1'b1, bt);
      $display("overrun: tvalid=%b tdata=%h ovr pulses=%0d", tvalid, tdata, ovr_n - o0);
      check("ovr_tvalid", {31'd0, tvalid}, 32'd1);
      check("ovr_tdata_kept", {24'd0, tdata}, 32'h11);
      check("ovr_be_tdata_kept", {24'd0, be_tdata}, 32'h88);
      check("ovr_pulse", ovr_n - o0, 32'd1);
      check("ovr_no_beat", beats - b0, 32'd0);
      tready = 1'b1;
      hold(1'b1, 4);
      check("ovr_drain_beat", beats - b0, 32'd1);
      check("ovr_drain_data", {24'd0, last_le}, 32'h11);
      check("ovr_drain_be", {24'd0, last_be}, 32'h88);
      check("ovr_tvalid_clear", {31'd0, tvalid}, 32'd0);
      hold(1'b1, bt);
      check("ovr_no_second", beats - b0, 32'd1);

      // Reset asserted in the middle of data bit 4.
      b0 = beats; f0 = ferr_n; o0 = ovr_n;
      hold(1'b0, bt);
      for (int i = 0; i < 4; i++) hold(1'b1 ^ i[0], bt);
      hold(1'b1, bt / 2);
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      hold(1'b1, 2);
      check("rst_tvalid", {31'd0, tvalid}, 32'd0);
      check("rst_tdata", {24'd0, tdata}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ferr", {31'd0, ferr}, 32'd0);
      check("rst_ovr", {31'd0, ovr}, 32'd0);
      rst = 1'b0;
      hold(1'b1, 2 * bt);
      check("rst_no_beat", beats - b0, 32'd0);
      check("rst_no_ferr", ferr_n - f0, 32'd0);
      check("rst_no_ovr", ovr_n - o0, 32'd0);
      send_frame(8'hA5, 1'b1, 1);
      hold(1'b1, bt);
      $display("post-reset frame: beats=%0d le=%h", beats - b0, last_le);
      check("post_rst_beat", beats - b0, 32'd1);
      check("post_rst_data", {24'd0, last_le}, 32'hA5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
